score_counter: RTL



---
 rtl/scoreboard_pkg.sv | 62 ++++++
 rtl/bcd_to_7seg.sv | 17 +
 rtl/score_counter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/scoreboard_pkg.sv
// Shared scoreboard definitions: seven-segment patterns, digit-select encodings
// and the per-cycle button event type.
package scoreboard_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;
    typedef logic [1:0] dig_sel_t;

    // Segment order is {a, b, c, d, e, f, g}, active-high.
    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam dig_sel_t DIG_ONES = 2'b01;
    localparam dig_sel_t DIG_TENS = 2'b10;

    typedef enum logic [1:0] {
        EvNone,
        EvUp,
        EvDown
    } evt_e;

    function automatic seg_t bcd_pattern(input bcd_t digit);
        seg_t pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Simultaneous up and down requests cancel each other out.
    function automatic evt_e resolve_evt(input logic up_evt, input logic down_evt);
        evt_e evt;
        if (up_evt && !down_evt) begin
            evt = EvUp;
        end else if (down_evt && !up_evt) begin
            evt = EvDown;
        end else begin
            evt = EvNone;
        end
        return evt;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment pattern decoder with blanking.
module bcd_to_7seg
    import scoreboard_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = bcd_pattern(bcd);
        end
    end

endmodule

// File: rtl/score_counter.sv
// Two-digit BCD score register with edge-detected up/down requests, limit or
// wrap handling, and a time-multiplexed two-digit seven-segment display.
module score_counter
    import scoreboard_pkg::*;
#(
    parameter int unsigned MAX_SCORE  = 99,
    parameter int unsigned WRAP       = 0,
    parameter int unsigned MUX_PERIOD = 5
) (
    input  logic       clk_1khz,
    input  logic       rst_i,
    input  logic       count_up,
    input  logic       count_down,
    output logic [3:0] score_tens_o,
    output logic [3:0] score_ones_o,
    output logic [6:0] seg_o,
    output logic [1:0] digit_sel_o,
    output logic       changed_o
);

    localparam bcd_t MAX_TENS = 4'(MAX_SCORE / 10);
    localparam bcd_t MAX_ONES = 4'(MAX_SCORE % 10);

    localparam int unsigned CNT_W = (MUX_PERIOD > 1) ? $clog2(MUX_PERIOD) : 1;
    localparam logic [CNT_W-1:0] MUX_LAST = CNT_W'(MUX_PERIOD - 1);

    logic up_q, down_q;
    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;
    logic changed_q, changed_d;
    logic [CNT_W-1:0] mux_cnt_q, mux_cnt_d;
    dig_sel_t sel_q, sel_d;

    logic up_evt, down_evt;
    logic at_max, at_zero;
    evt_e evt;

    logic disp_tens;
    bcd_t disp_digit;
    logic disp_blank;

    always_ff @(posedge clk_1khz) begin
        if (!rst_i) begin
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            changed_q <= 1'b0;
            mux_cnt_q <= '0;
            sel_q     <= DIG_ONES;
        end else begin
            up_q      <= count_up;
            down_q    <= count_down;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            changed_q <= changed_d;
            mux_cnt_q <= mux_cnt_d;
            sel_q     <= sel_d;
        end
    end

    assign up_evt   = count_up & ~up_q;
    assign down_evt = count_down & ~down_q;
    assign at_max   = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign at_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);

    always_comb begin
        evt       = resolve_evt(up_evt, down_evt);
        tens_d    = tens_q;
        ones_d    = ones_q;
        changed_d = 1'b0;
        unique case (evt)
            EvUp: begin
                if (at_max) begin
                    if (WRAP != 0) begin
                        tens_d    = 4'd0;
                        ones_d    = 4'd0;
                        changed_d = 1'b1;
                    end
                end else begin
                    changed_d = 1'b1;
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
            end
            EvDown: begin
                if (at_zero) begin
                    if (WRAP != 0) begin
                        tens_d    = MAX_TENS;
                        ones_d    = MAX_ONES;
                        changed_d = 1'b1;
                    end
                end else begin
                    changed_d = 1'b1;
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        mux_cnt_d = mux_cnt_q + 1'b1;
        sel_d     = sel_q;
        if (mux_cnt_q == MUX_LAST) begin
            mux_cnt_d = '0;
            sel_d     = (sel_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
        end
    end

    // Leading-zero blanking applies only to the tens position.
    always_comb begin
        disp_tens  = (sel_q == DIG_TENS);
        disp_digit = disp_tens ? tens_q : ones_q;
        disp_blank = disp_tens && (tens_q == 4'd0);
    end

    bcd_to_7seg u_seg (
        .bcd  (disp_digit),
        .blank(disp_blank),
        .seg  (seg_o)
    );

    assign score_tens_o = tens_q;
    assign score_ones_o = ones_q;
    assign digit_sel_o  = sel_q;
    assign changed_o    = changed_q;

endmodule
